arf_list_sched: RTL

- Resource-constrained executor for the 28-node ARF dataflow graph: 16 multiplies and 12 adds.
- Runs the whole graph on one shared pipelined multiplier and one shared single-cycle adder.
- A scoreboard-driven list scheduler picks the operation to issue on each unit every cycle.
- The block is the hardware counterpart of the ILP schedules produced for ARF. It accepts one 10-word operand bundle per run and returns the two filter outputs over valid/ready handshakes.

---
 rtl/arf_list_sched.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/arf_list_sched.sv
// ARF dataflow graph executor: one pipelined multiplier and one adder, each fed
// every cycle by a lowest-ready-node list scheduler over a done/issued scoreboard.
module arf_list_sched #(
   parameter int W       = 16,
   parameter int K       = 3,
   parameter int MUL_LAT = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [8*W-1:0] s_flat,
   input  logic [W-1:0]   f13,
   input  logic [W-1:0]   f14,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   y27,
   output logic [W-1:0]   y28,
   output logic           mul_iss_v,
   output logic [4:0]     mul_iss_id,
   output logic           add_iss_v,
   output logic [4:0]     add_iss_id,
   output logic           busy
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [W-1:0] K_POS = W'(K);
   localparam logic [W-1:0] K_NEG = -K_POS;
   // Bit n-1 set for every node n that executes on the multiplier.
   localparam logic [27:0] MUL_NODES = 28'b0000_1111_00_1111_000000_11111111;

   state_t         state, state_nxt;
   logic [27:0]    done, done_nxt;
   logic [27:0]    issued, issued_nxt;
   logic [W-1:0]   s_q [8];
   logic [W-1:0]   f13_q, f14_q;
   logic [W-1:0]   node_q [1:28];
   logic           accept;
   logic [W-1:0]   mul_a, mul_b, mul_prod;
   logic [W-1:0]   add_a, add_b, add_res;
   logic           mul_wb_v;
   logic [4:0]     mul_wb_id;
   logic [W-1:0]   mul_wb_data;

   function automatic logic [27:0] nb(input int n);
      return 28'b1 << (n - 1);
   endfunction

   function automatic logic [27:0] src_of(input int n);
      logic [27:0] m;
      m = '0;
      case (n)
         9:       m = nb(1)  | nb(2);
         10:      m = nb(3)  | nb(4);
         11:      m = nb(5)  | nb(6);
         12:      m = nb(7)  | nb(8);
         13:      m = nb(10);
         14:      m = nb(11);
         15, 17:  m = nb(13);
         16, 18:  m = nb(14);
         19:      m = nb(15) | nb(16);
         20:      m = nb(17) | nb(18);
         21, 23:  m = nb(19);
         22, 24:  m = nb(20);
         25:      m = nb(21) | nb(22);
         26:      m = nb(23) | nb(24);
         27:      m = nb(9)  | nb(25);
         28:      m = nb(12) | nb(26);
         default: m = '0;
      endcase
      return m;
   endfunction

   assign accept = in_valid & in_ready;

   // State register plus scoreboard; a new bundle starts with a clean scoreboard.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         done   <= '0;
         issued <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            done   <= '0;
            issued <= '0;
         end else begin
            done   <= done_nxt;
            issued <= issued_nxt;
         end
      end
   end

   // Next state and handshake outputs; results are exposed only while in DONE.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      y27       = '0;
      y28       = '0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (done_nxt[26] && done_nxt[27]) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            y27       = node_q[27];
            y28       = node_q[28];
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Descending scan so the lowest-numbered ready node wins on each unit.
   always_comb begin
      mul_iss_v  = 1'b0;
      mul_iss_id = '0;
      add_iss_v  = 1'b0;
      add_iss_id = '0;
      if (state == RUN) begin
         for (int n = 28; n >= 1; n--) begin
            if (!issued[n-1] && ((done & src_of(n)) == src_of(n))) begin
               if (MUL_NODES[n-1]) begin
                  mul_iss_v  = 1'b1;
                  mul_iss_id = 5'(n);
               end else begin
                  add_iss_v  = 1'b1;
                  add_iss_id = 5'(n);
               end
            end
         end
      end
   end

   always_comb begin
      done_nxt   = done;
      issued_nxt = issued;
      if (add_iss_v) begin
         done_nxt   = done_nxt | nb(int'(add_iss_id));
         issued_nxt = issued_nxt | nb(int'(add_iss_id));
      end
      if (mul_iss_v) issued_nxt = issued_nxt | nb(int'(mul_iss_id));
      if (mul_wb_v)  done_nxt   = done_nxt | nb(int'(mul_wb_id));
   end

   // Nodes 21, 22 and 23 use the negated coefficient.
   always_comb begin
      mul_a = '0;
      mul_b = K_POS;
      case (mul_iss_id)
         5'd1, 5'd2, 5'd3, 5'd4,
         5'd5, 5'd6, 5'd7, 5'd8: mul_a = s_q[mul_iss_id[2:0] - 3'd1];
         5'd15, 5'd17:           mul_a = node_q[13];
         5'd16, 5'd18:           mul_a = node_q[14];
         5'd21, 5'd23: begin
            mul_a = node_q[19];
            mul_b = K_NEG;
         end
         5'd22: begin
            mul_a = node_q[20];
            mul_b = K_NEG;
         end
         5'd24:                  mul_a = node_q[20];
         default:                mul_a = '0;
      endcase
   end

   assign mul_prod = mul_a * mul_b;

   always_comb begin
      add_a = '0;
      add_b = '0;
      case (add_iss_id)
         5'd9:  begin add_a = node_q[1];  add_b = node_q[2];  end
         5'd10: begin add_a = node_q[3];  add_b = node_q[4];  end
         5'd11: begin add_a = node_q[5];  add_b = node_q[6];  end
         5'd12: begin add_a = node_q[7];  add_b = node_q[8];  end
         5'd13: begin add_a = node_q[10]; add_b = f13_q;      end
         5'd14: begin add_a = node_q[11]; add_b = f14_q;      end
         5'd19: begin add_a = node_q[15]; add_b = node_q[16]; end
         5'd20: begin add_a = node_q[17]; add_b = node_q[18]; end
         5'd25: begin add_a = node_q[21]; add_b = node_q[22]; end
         5'd26: begin add_a = node_q[23]; add_b = node_q[24]; end
         5'd27: begin add_a = node_q[9];  add_b = node_q[25]; end
         5'd28: begin add_a = node_q[12]; add_b = node_q[26]; end
         default: begin add_a = '0; add_b = '0; end
      endcase
   end

   assign add_res = add_a + add_b;

   // The product is formed at issue; MUL_LAT-1 register stages delay its writeback.
   generate
      if (MUL_LAT == 1) begin : g_mul_comb
         assign mul_wb_v    = mul_iss_v;
         assign mul_wb_id   = mul_iss_id;
         assign mul_wb_data = mul_prod;
      end else begin : g_mul_pipe
         logic         pv  [MUL_LAT-1];
         logic [4:0]   pid [MUL_LAT-1];
         logic [W-1:0] pd  [MUL_LAT-1];

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < MUL_LAT-1; i++) pv[i] <= 1'b0;
            end else begin
               pv[0] <= mul_iss_v;
               for (int i = 1; i < MUL_LAT-1; i++) pv[i] <= pv[i-1];
            end
            pid[0] <= mul_iss_id;
            pd[0]  <= mul_prod;
            for (int i = 1; i < MUL_LAT-1; i++) begin
               pid[i] <= pid[i-1];
               pd[i]  <= pd[i-1];
            end
         end

         assign mul_wb_v    = pv[MUL_LAT-2];
         assign mul_wb_id   = pid[MUL_LAT-2];
         assign mul_wb_data = pd[MUL_LAT-2];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = 0; i < 8; i++) s_q[i] <= s_flat[i*W +: W];
         f13_q <= f13;
         f14_q <= f14;
      end
   end

   always_ff @(posedge clk) begin
      if (add_iss_v) node_q[add_iss_id] <= add_res;
      if (mul_wb_v)  node_q[mul_wb_id]  <= mul_wb_data;
   end

endmodule
